seq_lock_ctrl: RTL and testbench

- Controller for the 2-bit symbol sequence detector. Groups incoming symbols into 3-symbol attempts and compares each attempt against a programmed code.
- A correct attempt grants a timed "open" window. Failed attempts are counted, and MAX_FAIL consecutive failures force a timed lockout.
- Sits between the symbol source (keypad/serial decoder) and the actuator/status logic.

---
 rtl/seq_pkg.sv | 18 +
 rtl/seq_lock_ctrl_if.sv | 26 ++
 rtl/seq_timer.sv | 26 ++
 rtl/seq_lock_ctrl.sv | 150 +++++++++++++++
 tb/tb_seq_lock_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared types and default code for the symbol sequence lock controller.
package seq_pkg;

  typedef logic [1:0] symbol_t;

  typedef enum logic [2:0] {
    S0,
    S1,
    S2,
    OPEN,
    LOCK
  } state_t;

  localparam symbol_t DEF_CODE0 = 2'b01;
  localparam symbol_t DEF_CODE1 = 2'b10;
  localparam symbol_t DEF_CODE2 = 2'b11;

endpackage

// File: rtl/seq_lock_ctrl_if.sv
// Symbol-in / status-out bundle between the symbol source and the lock controller.
interface seq_lock_ctrl_if #(
  parameter int unsigned FW = 2
);
  import seq_pkg::*;

  logic          sym_valid;
  symbol_t       sym;
  logic          clear;
  logic          open;
  logic          locked;
  logic          err;
  logic [1:0]    progress;
  logic [FW-1:0] fail_cnt;

  modport master (
    output sym_valid, sym, clear,
    input  open, locked, err, progress, fail_cnt
  );

  modport slave (
    input  sym_valid, sym, clear,
    output open, locked, err, progress, fail_cnt
  );

endinterface

// File: rtl/seq_timer.sv
// Loadable down-counter that stops at zero; times both the open and lockout windows.
module seq_timer #(
  parameter int unsigned TW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  output logic          o_zero_c
);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - TW'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/seq_lock_ctrl.sv
// Groups 2-bit symbols into 3-symbol attempts, opens on a code match and
// locks out after MAX_FAIL consecutive misses.
module seq_lock_ctrl
  import seq_pkg::*;
#(
  parameter symbol_t     CODE0       = DEF_CODE0,
  parameter symbol_t     CODE1       = DEF_CODE1,
  parameter symbol_t     CODE2       = DEF_CODE2,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned OPEN_CYCLES = 8,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  seq_lock_ctrl_if.slave  bus
);

  localparam int unsigned FW      = $clog2(MAX_FAIL + 1);
  localparam int unsigned WIN_MAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int unsigned TW      = $clog2(WIN_MAX + 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_ok;
  logic          w_ok_nxt;
  logic [FW-1:0] r_fail_cnt;
  logic [FW-1:0] w_fail_nxt;
  logic          w_err_nxt;
  logic          w_load;
  logic [TW-1:0] w_load_val;
  logic          w_tmr_zero;
  logic          w_last_fail;
  logic [1:0]    w_progress_nxt;

  logic          r_open;
  logic          r_locked;
  logic          r_err;
  logic [1:0]    r_progress;

  seq_timer #(.TW(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero_c   (w_tmr_zero)
  );

  assign w_last_fail = ((32'(r_fail_cnt) + 32'd1) == 32'(MAX_FAIL));

  // State, match flag, failure count and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S0;
      r_ok       <= 1'b0;
      r_fail_cnt <= '0;
      r_open     <= 1'b0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
      r_progress <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_ok       <= w_ok_nxt;
      r_fail_cnt <= w_fail_nxt;
      r_open     <= (w_state_nxt == OPEN);
      r_locked   <= (w_state_nxt == LOCK);
      r_err      <= w_err_nxt;
      r_progress <= w_progress_nxt;
    end
  end

  // Mismatches only fold into ok, so a miss is reported after the full attempt
  always_comb begin
    w_state_nxt = r_state;
    w_ok_nxt    = r_ok;
    w_fail_nxt  = r_fail_cnt;
    w_err_nxt   = 1'b0;
    w_load      = 1'b0;
    w_load_val  = '0;

    case (r_state)
      S0: begin
        if (bus.sym_valid) begin
          w_ok_nxt    = (bus.sym == CODE0);
          w_state_nxt = S1;
        end
      end
      S1: begin
        if (bus.clear) begin
          w_state_nxt = S0;
        end else if (bus.sym_valid) begin
          w_ok_nxt    = r_ok & (bus.sym == CODE1);
          w_state_nxt = S2;
        end
      end
      S2: begin
        if (bus.clear) begin
          w_state_nxt = S0;
        end else if (bus.sym_valid) begin
          if (r_ok && (bus.sym == CODE2)) begin
            w_state_nxt = OPEN;
            w_fail_nxt  = '0;
            w_load      = 1'b1;
            w_load_val  = TW'(OPEN_CYCLES - 1);
          end else begin
            w_err_nxt = 1'b1;
            if (w_last_fail) begin
              w_state_nxt = LOCK;
              w_fail_nxt  = FW'(MAX_FAIL);
              w_load      = 1'b1;
              w_load_val  = TW'(LOCK_CYCLES - 1);
            end else begin
              w_state_nxt = S0;
              w_fail_nxt  = r_fail_cnt + FW'(1);
            end
          end
        end
      end
      OPEN: begin
        if (w_tmr_zero) begin
          w_state_nxt = S0;
        end
      end
      LOCK: begin
        if (w_tmr_zero) begin
          w_state_nxt = S0;
          w_fail_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = S0;
      end
    endcase
  end

  always_comb begin
    w_progress_nxt = 2'd0;
    case (w_state_nxt)
      S1:      w_progress_nxt = 2'd1;
      S2:      w_progress_nxt = 2'd2;
      default: w_progress_nxt = 2'd0;
    endcase
  end

  assign bus.open     = r_open;
  assign bus.locked   = r_locked;
  assign bus.err      = r_err;
  assign bus.progress = r_progress;
  assign bus.fail_cnt = r_fail_cnt;

endmodule

// File: tb/tb_seq_lock_ctrl.sv
// Directed plus randomized bench for seq_lock_ctrl against a queue-based attempt model.
module tb_seq_lock_ctrl;
  import seq_pkg::*;

  localparam int MAX_FAIL    = 3;
  localparam int OPEN_CYCLES = 8;
  localparam int LOCK_CYCLES = 16;
  localparam int FW          = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seq_lock_ctrl_if #(.FW(FW)) bus_if ();

  seq_lock_ctrl #(
    .CODE0       (2'b01),
    .CODE1       (2'b10),
    .CODE2       (2'b11),
    .MAX_FAIL    (MAX_FAIL),
    .OPEN_CYCLES (OPEN_CYCLES),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: symbols collected so far, remaining window cycles, consecutive misses
  logic [1:0] m_buf[$];
  logic [1:0] code[3] = '{2'b01, 2'b10, 2'b11};
  int         m_open_left = 0;
  int         m_lock_left = 0;
  int         m_fail      = 0;
  bit         m_err       = 1'b0;

  int open_seen = 0;
  int lock_seen = 0;
  int err_seen  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit v, input logic [1:0] s, input bit c, input bit r);
    m_err = 1'b0;
    if (!r) begin
      m_open_left = 0;
      m_lock_left = 0;
      m_fail      = 0;
      m_buf.delete();
    end else if (m_open_left > 0) begin
      m_open_left--;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fail = 0;
    end else if (c && m_buf.size() > 0) begin
      m_buf.delete();
    end else if (v) begin
      m_buf.push_back(s);
      if (m_buf.size() == 3) begin
        if (m_buf[0] == code[0] && m_buf[1] == code[1] && m_buf[2] == code[2]) begin
          m_open_left = OPEN_CYCLES;
          m_fail      = 0;
        end else begin
          m_err = 1'b1;
          m_fail++;
          if (m_fail == MAX_FAIL) m_lock_left = LOCK_CYCLES;
        end
        m_buf.delete();
      end
    end
  endtask

  task automatic step(input bit v, input logic [1:0] s, input bit c, input bit r);
    bus_if.sym_valid = v;
    bus_if.sym       = s;
    bus_if.clear     = c;
    reset            = r;
    model_edge(v, s, c, r);
    @(posedge clk);
    #1;
    chk("open",     32'(bus_if.open),     32'(m_open_left > 0));
    chk("locked",   32'(bus_if.locked),   32'(m_lock_left > 0));
    chk("err",      32'(bus_if.err),      32'(m_err));
    chk("progress", 32'(bus_if.progress), 32'(m_buf.size()));
    chk("fail_cnt", 32'(bus_if.fail_cnt), 32'(m_fail));
    if (bus_if.open === 1'b1)   open_seen++;
    if (bus_if.locked === 1'b1) lock_seen++;
    if (bus_if.err === 1'b1)    err_seen++;
  endtask

  task automatic sym_in(input logic [1:0] s);
    step(1'b1, s, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic good_code();
    sym_in(2'b01); sym_in(2'b10); sym_in(2'b11);
  endtask

  task automatic bad_code();
    sym_in(2'b00); sym_in(2'b00); sym_in(2'b00);
  endtask

  initial begin
    bit         v;
    bit         c;
    bit         r;
    logic [1:0] s;

    do_reset(2);
    chk("reset_fail_cnt", 32'(bus_if.fail_cnt), 32'd0);

    // Correct code opens for exactly OPEN_CYCLES
    open_seen = 0; err_seen = 0;
    good_code();
    idle(10);
    chk("t1_open_len", 32'(open_seen), 32'(OPEN_CYCLES));
    chk("t1_no_err",   32'(err_seen),  32'd0);

    // One miss, then the correct code
    err_seen = 0; open_seen = 0;
    sym_in(2'b01); sym_in(2'b00); sym_in(2'b11);
    chk("t2_fail1", 32'(bus_if.fail_cnt), 32'd1);
    idle(2);
    good_code();
    idle(10);
    chk("t2_err_cnt",  32'(err_seen),  32'd1);
    chk("t2_open_len", 32'(open_seen), 32'(OPEN_CYCLES));

    // Three misses lock out; code sent during lockout is ignored
    err_seen = 0; lock_seen = 0; open_seen = 0;
    bad_code(); bad_code(); bad_code();
    good_code();
    idle(16);
    chk("t3_err_cnt",  32'(err_seen),  32'd3);
    chk("t3_lock_len", 32'(lock_seen), 32'(LOCK_CYCLES));
    chk("t3_no_open",  32'(open_seen), 32'd0);
    good_code();
    idle(10);
    chk("t3_reopen",   32'(open_seen), 32'(OPEN_CYCLES));

    // Gapped entry then clear alongside the final symbol
    err_seen = 0; open_seen = 0;
    bad_code();
    sym_in(2'b01); idle(2); sym_in(2'b10); idle(1);
    step(1'b1, 2'b11, 1'b1, 1'b1);
    chk("t4_progress", 32'(bus_if.progress), 32'd0);
    chk("t4_fail_kept", 32'(bus_if.fail_cnt), 32'd1);
    idle(3);
    chk("t4_no_open", 32'(open_seen), 32'd0);

    // Code repeated during the open window is ignored
    open_seen = 0;
    good_code();
    good_code();
    idle(8);
    chk("t5_open_len", 32'(open_seen), 32'(OPEN_CYCLES));

    // Reset mid-lockout and mid-attempt
    bad_code(); bad_code(); bad_code();
    idle(4);
    do_reset(1);
    chk("t6_lock_rst", 32'(bus_if.locked), 32'd0);
    sym_in(2'b01); sym_in(2'b10);
    do_reset(1);
    chk("t6_prog_rst", 32'(bus_if.progress), 32'd0);
    open_seen = 0;
    good_code();
    idle(10);
    chk("t6_open_len", 32'(open_seen), 32'(OPEN_CYCLES));

    // Randomized traffic biased toward the code so both opens and lockouts occur
    for (int i = 0; i < 1500; i++) begin
      v = ($urandom_range(0, 9) < 6);
      c = ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 9) < 7 && m_buf.size() < 3) s = code[m_buf.size()];
      else s = 2'($urandom_range(0, 3));
      step(v, s, c, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
